// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_if
// Description : Bundle between the EX/ID stages and the central stall
//               controller. It carries the stall requests, the multi-cycle
//               op handshake and perf-counter clear into the controller. It
//               carries the per-stage stall vector, busy flag and stall-cycle
//               count back out.
//               master : pipeline side (drives requests, consumes stall)
//               slave  : stall controller
// Revision    : 1.0  initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
    parameter int MC_W  = 6,
    parameter int CNT_W = 32
);
    logic              stallreq_from_id;
    logic              stallreq_from_ex;
    logic              ex_mc_start;
    logic [MC_W-1:0]   ex_mc_cycles;
    logic              ex_mc_done;
    logic              perf_clr;
    logic [5:0]        stall;
    logic              mc_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output stallreq_from_id, stallreq_from_ex, ex_mc_start,
               ex_mc_cycles, ex_mc_done, perf_clr,
        input  stall, mc_busy, stall_cnt
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, ex_mc_start,
               ex_mc_cycles, ex_mc_done, perf_clr,
        output stall, mc_busy, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central pipeline stall controller. It merges the ID and EX
//               stall requests and sequences multi-cycle EX ops from a start
//               pulse and a length. It also keeps a saturating count of
//               stalled cycles.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - pipe_stall_ctrl_if.slave:
//                      stall[5:0] bit0 pc .. bit5 wb, 1 = stop
//                      mc_busy    high while sequencing a multi-cycle op
//                      stall_cnt  cycles with stall[0] set, saturating
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int MC_W  = 6,
    parameter int CNT_W = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipe_stall_ctrl_if.slave   bus
);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_MC_BUSY = 1'b1;

    localparam logic [5:0] c_STALL_EX   = 6'b001111;
    localparam logic [5:0] c_STALL_ID   = 6'b000111;
    localparam logic [5:0] c_STALL_NONE = 6'b000000;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [MC_W-1:0]  r_count;
    logic [MC_W-1:0]  w_count_nxt;
    logic [MC_W-1:0]  w_n_eff;
    logic             w_long_op;
    logic             w_mc_hold;
    logic [5:0]       w_stall;
    logic             w_mc_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    // A zero-length op behaves exactly like a one-cycle op.
    assign w_n_eff   = (bus.ex_mc_cycles == '0) ? MC_W'(1) : bus.ex_mc_cycles;
    assign w_long_op = (w_n_eff >= MC_W'(2));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state logic. The start cycle already holds the pipeline, so the
    // countdown loaded here covers the remaining N-2 held cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            c_IDLE: begin
                if (bus.ex_mc_start && w_long_op) begin
                    w_state_nxt = c_MC_BUSY;
                    w_count_nxt = w_n_eff - MC_W'(2);
                end
            end
            c_MC_BUSY: begin
                if (bus.ex_mc_done || (r_count == '0)) begin
                    w_state_nxt = c_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count - MC_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // Output logic. The outputs are forced quiet while rst is high, because
    // the registered state only clears at the next edge.
    always_comb begin
        w_mc_hold = 1'b0;
        case (r_state)
            c_IDLE:    w_mc_hold = bus.ex_mc_start && w_long_op;
            c_MC_BUSY: w_mc_hold = !bus.ex_mc_done && (r_count != '0);
            default:   w_mc_hold = 1'b0;
        endcase

        w_mc_busy = !rst && (r_state == c_MC_BUSY);

        if (rst)
            w_stall = c_STALL_NONE;
        else if (w_mc_hold || bus.stallreq_from_ex)
            w_stall = c_STALL_EX;
        else if (bus.stallreq_from_id)
            w_stall = c_STALL_ID;
        else
            w_stall = c_STALL_NONE;
    end

    // Stall-cycle performance counter. A clear wins over a count in the
    // same cycle.
    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr)
            r_stall_cnt <= '0;
        else if (w_stall[0] && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign bus.stall     = w_stall;
    assign bus.mc_busy   = w_mc_busy;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed testbench for pipe_stall_ctrl. The main instance
//               uses a 32-bit counter. A second instance with a 3-bit counter
//               exercises saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    typedef struct {
        string      tag;
        logic [5:0] st;
        logic       busy;
        int         cnt;   // negative: count not checked this step
    } exp_t;

    logic clk;
    logic rst;
    logic rst_s;
    int   errors;
    int   checks;
    exp_t sb[$];

    pipe_stall_ctrl_if #(.MC_W(6), .CNT_W(32)) bus ();
    pipe_stall_ctrl_if #(.MC_W(6), .CNT_W(3))  bus_s ();

    pipe_stall_ctrl #(.MC_W(6), .CNT_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_stall_ctrl #(.MC_W(6), .CNT_W(3)) u_dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle on the main instance: drive at negedge, queue the expected
    // response, then pop and compare after the inputs settle.
    task automatic step(input string tag, input logic r, input logic ex,
                        input logic id, input logic start, input logic [5:0] cyc,
                        input logic done, input logic clr,
                        input logic [5:0] es, input logic eb, input int ec);
        exp_t e;
        @(negedge clk);
        rst                  = r;
        bus.stallreq_from_ex = ex;
        bus.stallreq_from_id = id;
        bus.ex_mc_start      = start;
        bus.ex_mc_cycles     = cyc;
        bus.ex_mc_done       = done;
        bus.perf_clr         = clr;
        sb.push_back('{tag, es, eb, ec});
        #1;
        e = sb.pop_front();
        checks++;
        assert (bus.stall === e.st) else begin
            errors++;
            $error("FAIL %s stall: observed %b expected %b", e.tag, bus.stall, e.st);
        end
        checks++;
        assert (bus.mc_busy === e.busy) else begin
            errors++;
            $error("FAIL %s mc_busy: observed %b expected %b", e.tag, bus.mc_busy, e.busy);
        end
        if (e.cnt >= 0) begin
            checks++;
            assert (bus.stall_cnt === 32'(e.cnt)) else begin
                errors++;
                $error("FAIL %s stall_cnt: observed %0d expected %0d", e.tag, bus.stall_cnt, e.cnt);
            end
        end
    endtask

    // One cycle on the 3-bit-counter instance.
    task automatic step_s(input string tag, input logic ex,
                          input logic [5:0] es, input int ec);
        exp_t e;
        @(negedge clk);
        rst_s                  = 1'b0;
        bus_s.stallreq_from_ex = ex;
        sb.push_back('{tag, es, 1'b0, ec});
        #1;
        e = sb.pop_front();
        checks++;
        assert (bus_s.stall === e.st) else begin
            errors++;
            $error("FAIL %s stall: observed %b expected %b", e.tag, bus_s.stall, e.st);
        end
        checks++;
        assert (bus_s.stall_cnt === 3'(e.cnt)) else begin
            errors++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", e.tag, bus_s.stall_cnt, e.cnt);
        end
    endtask

    localparam logic [5:0] SE = 6'b001111;
    localparam logic [5:0] SI = 6'b000111;
    localparam logic [5:0] S0 = 6'b000000;

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        rst_s  = 1'b1;
        bus.stallreq_from_ex = 1'b0; bus.stallreq_from_id = 1'b0;
        bus.ex_mc_start = 1'b0; bus.ex_mc_cycles = '0;
        bus.ex_mc_done = 1'b0; bus.perf_clr = 1'b0;
        bus_s.stallreq_from_ex = 1'b0; bus_s.stallreq_from_id = 1'b0;
        bus_s.ex_mc_start = 1'b0; bus_s.ex_mc_cycles = '0;
        bus_s.ex_mc_done = 1'b0; bus_s.perf_clr = 1'b0;

        //    tag          rst  ex   id   st   cyc done clr  stall busy cnt
        // Reset dominates an EX request
        step("rst0",       1,   1,   0,   0,   0,  0,   0,   S0,   0,  -1);
        step("rst1",       1,   1,   0,   0,   0,  0,   0,   S0,   0,   0);
        step("rel_ex",     0,   1,   0,   0,   0,  0,   0,   SE,   0,   0);
        // Priority
        step("id_only",    0,   0,   1,   0,   0,  0,   0,   SI,   0,   1);
        step("id_ex",      0,   1,   1,   0,   0,  0,   0,   SE,   0,   2);
        step("none",       0,   0,   0,   0,   0,  0,   0,   S0,   0,   3);
        step("clr",        0,   0,   0,   0,   0,  0,   1,   S0,   0,   3);
        step("cleared",    0,   0,   0,   0,   0,  0,   0,   S0,   0,   0);
        // N=5: four held cycles, busy for the four after the start
        step("n5_t0",      0,   0,   0,   1,   5,  0,   0,   SE,   0,   0);
        step("n5_t1",      0,   0,   0,   0,   0,  0,   0,   SE,   1,   1);
        step("n5_t2",      0,   0,   0,   0,   0,  0,   0,   SE,   1,   2);
        step("n5_t3",      0,   0,   0,   0,   0,  0,   0,   SE,   1,   3);
        step("n5_t4",      0,   0,   0,   0,   0,  0,   0,   S0,   1,   4);
        step("n5_idle",    0,   0,   0,   0,   0,  0,   1,   S0,   0,   4);
        // N=1 and N=0: no hold
        step("n1",         0,   0,   0,   1,   1,  0,   0,   S0,   0,   0);
        step("n1_after",   0,   0,   0,   0,   0,  0,   0,   S0,   0,   0);
        step("n0",         0,   0,   0,   1,   0,  0,   0,   S0,   0,   0);
        step("n0_after",   0,   0,   0,   0,   0,  0,   0,   S0,   0,   0);
        // N=2: one held cycle, one busy cycle
        step("n2_t0",      0,   0,   0,   1,   2,  0,   0,   SE,   0,   0);
        step("n2_t1",      0,   0,   0,   0,   0,  0,   0,   S0,   1,   1);
        step("n2_idle",    0,   0,   0,   0,   0,  0,   0,   S0,   0,   1);
        // N=20 with early done; done in the start cycle is ignored
        step("n20_t0",     0,   0,   0,   1,  20,  1,   0,   SE,   0,   1);
        step("n20_t1",     0,   0,   0,   0,   0,  0,   0,   SE,   1,   2);
        step("n20_t2",     0,   0,   0,   0,   0,  0,   0,   SE,   1,   3);
        step("n20_done",   0,   0,   0,   0,   0,  1,   0,   S0,   1,   4);
        // Back-to-back N=3; ID request absorbed, EX request on release cycle
        step("n3_t0",      0,   0,   0,   1,   3,  0,   0,   SE,   0,   4);
        step("n3_t1_id",   0,   0,   1,   0,   0,  0,   0,   SE,   1,   5);
        step("n3_rel_ex",  0,   1,   0,   0,   0,  0,   0,   SE,   1,   6);
        step("idle_done",  0,   0,   0,   0,   0,  1,   0,   S0,   0,   7);
        // Reset mid-op: no resume
        step("n10_t0",     0,   0,   0,   1,  10,  0,   0,   SE,   0,   7);
        step("n10_t1",     0,   0,   0,   0,   0,  0,   0,   SE,   1,   8);
        step("n10_rst",    1,   0,   0,   0,   0,  0,   0,   S0,   0,   9);
        step("post_rst0",  0,   0,   0,   0,   0,  0,   0,   S0,   0,   0);
        step("post_rst1",  0,   0,   0,   0,   0,  0,   0,   S0,   0,   0);
        // Clear concurrent with a stall
        step("pc_ex",      0,   1,   0,   0,   0,  0,   0,   SE,   0,   0);
        step("pc_ex_clr",  0,   1,   0,   0,   0,  0,   1,   SE,   0,   1);
        step("pc_after",   0,   0,   0,   0,   0,  0,   0,   S0,   0,   0);

        // Saturation on the 3-bit counter: ten stalled cycles
        for (int k = 0; k < 10; k++)
            step_s($sformatf("sat%0d", k), 1'b1, SE, (k > 7) ? 7 : k);
        step_s("sat_hold0", 1'b0, S0, 7);
        step_s("sat_hold1", 1'b0, S0, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall controller that drives the 6-bit `stall` vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb).
- Merges combinational stall requests from the ID and EX stages.
- Sequences multi-cycle EX operations (mult-accumulate, divide) with an internal counter, so the EX unit only needs a start pulse and an optional early-done signal.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MC_W, 6, width of the multi-cycle length field and internal countdown
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stallreq_from_id  input  1  ID hazard (load-use), 1 = request stall
stallreq_from_ex  input  1  EX single-cycle stall request, 1 = request stall
ex_mc_start  input  1  pulse: EX begins a multi-cycle op this cycle
ex_mc_cycles  input  MC_W  total EX occupancy N of the op, sampled with ex_mc_start
ex_mc_done  input  1  EX result ready early; ends the multi-cycle hold
perf_clr  input  1  clear the stall counter
stall  output  6  per-stage stop: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = Stop
mc_busy  output  1  1 while in MC_BUSY state
stall_cnt  output  CNT_W  cycles with stall[0]=1, saturating

Behaviour:
- Reset, synchronous, active-high. While rst=1:
  - state = IDLE, countdown = 0, stall_cnt = 0.
  - stall = 6'b000000 combinationally, mc_busy = 0.
  - Reset mid-op aborts the op; the hold is not resumed after reset.
- Stall vector is combinational from the current inputs and registered state, with no added latency. Priority, highest first:
  1. EX-level hold (stallreq_from_ex, or a multi-cycle hold active per the rules below) → 6'b001111: pc, if, id, ex held; mem, wb run. id_ex keeps its contents; ex_mem receives a bubble.
  2. stallreq_from_id → 6'b000111: pc, if, id held; id_ex inserts a NOP.
  3. Otherwise → 6'b000000.
- Effective length: N = ex_mc_cycles, with N = 0 treated as 1.
- State machine: IDLE, MC_BUSY.
- IDLE:
  - ex_mc_start=1 with N≥2: EX hold asserted this cycle; countdown ← N−2; next state MC_BUSY.
  - ex_mc_start=1 with N=1: no hold, stay IDLE.
- MC_BUSY, mc_busy=1:
  - ex_mc_done=1 or countdown==0: no multi-cycle hold this cycle (release); next state IDLE. stallreq_from_ex / stallreq_from_id still apply on the release cycle.
  - Otherwise: EX hold asserted; countdown decrements.
  - ex_mc_start is ignored (EX is held and cannot issue).
- Net effect: an op of length N asserts 6'b001111 for exactly N−1 consecutive cycles starting at the start cycle. The pipeline advances in cycle start+N−1, or in the cycle ex_mc_done is seen.
- ex_mc_done in IDLE: ignored.
- ex_mc_done in the start cycle: ignored (takes effect only in MC_BUSY).
- Simultaneous stallreq_from_id during a hold: output stays 6'b001111; ID request is absorbed.
- Stall counter, per clock edge with rst=0:
  - perf_clr=1 → stall_cnt ← 0. Clear takes priority; no increment that cycle.
  - Else if stall[0]=1 and stall_cnt ≠ all-ones → increment.
  - At all-ones → hold (saturate, no wrap).
- Countdown arithmetic is MC_W bits unsigned. N−2 is computed only for N≥2, so it never underflows.

Test Plan:
- Reset → rst=1 for 2 cycles while stallreq_from_ex=1 → stall=000000, mc_busy=0, stall_cnt=0. After release: stall=001111 on the next cycle.
- Priority → stallreq_from_id=1 alone → stall=000111. Add stallreq_from_ex=1 in the same cycle → 001111. Both 0 → 000000.
- Multi-cycle, N=5, start at cycle t → stall=001111 for t..t+3, 000000 at t+4. mc_busy=1 for t+1..t+4. stall_cnt=4.
- Multi-cycle, N=1 and N=0 → no stall, mc_busy stays 0. N=2 → exactly one stall cycle, mc_busy high one cycle.
- Early done → N=20, ex_mc_done=1 at t+3 → stall=001111 for t..t+2, 000000 at t+3, IDLE at t+4. A new start at t+4 with N=3 → stall at t+4, t+5.
- Reset mid-op and counter edges:
  - rst at t+2 of an N=10 op → stall 000000 from t+2, IDLE, no resume.
  - Preload via CNT_W=3: hold stall 10 cycles → stall_cnt=7, saturated.
  - perf_clr together with stall → stall_cnt=0 the next cycle.
